// File: rtl/rca_pkg.sv
// Shared constants for the rca_pipe_sub pipelined subtractor.
//   RCA_WIDTH_DEF : default operand/result width in bits
//   RCA_SUB_LAT   : input-to-output latency in enabled clock edges
package rca_pkg;

    localparam int unsigned RCA_WIDTH_DEF = 4;
    localparam int unsigned RCA_SUB_LAT   = 2;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - bin, with the borrow out on bout.
// Ports:
//   x, y  : minuend and subtrahend bits
//   bin   : borrow in from the next-lower bit
//   d     : difference bit
//   bout  : borrow out to the next-higher bit
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/rca_pipe_sub.sv
// Two-stage pipelined computation of F = (A - B - C - D) mod 2^WIDTH with a
// negative-result flag.
//   Stage 1 registers d1 = A - B (WIDTH+1 bit two's complement) and
//   s1 = C + D (WIDTH+1 bit unsigned). Stage 2 registers F and uf from d1 - s1.
// All arithmetic is built from ripple chains; no vector +/- operators.
// Build option: define RCA_SUB_SAT_EN to clamp F to 0 whenever the true result
// is negative (uf behaves the same in both builds).
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : pipeline advance enable; low holds every stage
//   in_valid   : A/B/C/D carry a valid operand set
//   A, B, C, D : unsigned operands
//   F          : result
//   uf         : true result was negative
//   out_valid  : F/uf carry a valid result
module rca_pipe_sub
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] F,
    output logic             uf,
    output logic             out_valid
);

    // The most negative result, -3*(2^WIDTH-1), needs one bit more than
    // WIDTH+2 to keep its sign, so stage 2 works in WIDTH+3 bits.
    localparam int unsigned RW = WIDTH + 3;

    // ---------------- stage 1: A - B and C + D ----------------
    logic [WIDTH:0]   bw1;
    logic [WIDTH-1:0] diff1;
    logic [WIDTH:0]   cy1;
    logic [WIDTH-1:0] sum1;
    logic [WIDTH:0]   d1_d;
    logic [WIDTH:0]   s1_d;

    assign bw1[0] = 1'b0;
    assign cy1[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sub1
        fs_cell u_fs (
            .x    (A[i]),
            .y    (B[i]),
            .bin  (bw1[i]),
            .d    (diff1[i]),
            .bout (bw1[i+1])
        );
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_add1
        assign sum1[i]  = C[i] ^ D[i] ^ cy1[i];
        assign cy1[i+1] = (C[i] & D[i]) | (cy1[i] & (C[i] ^ D[i]));
    end

    // Borrow out of an unsigned WIDTH-bit subtraction is exactly the sign of
    // the WIDTH+1 bit two's-complement difference.
    assign d1_d = {bw1[WIDTH], diff1};
    assign s1_d = {cy1[WIDTH], sum1};

    logic [WIDTH:0] d1_q;
    logic [WIDTH:0] s1_q;
    logic           v1_q;

    // ---------------- stage 2: d1 - s1 ----------------
    logic [RW-1:0]    x2;
    logic [RW-1:0]    y2;
    logic [RW:0]      bw2;
    logic [RW-1:0]    r;
    logic             neg;
    logic [WIDTH-1:0] f_d;
    logic             unused_bits;

    assign x2     = {{2{d1_q[WIDTH]}}, d1_q};
    assign y2     = {2'b00, s1_q};
    assign bw2[0] = 1'b0;

    for (genvar i = 0; i < RW; i++) begin : g_sub2
        fs_cell u_fs (
            .x    (x2[i]),
            .y    (y2[i]),
            .bin  (bw2[i]),
            .d    (r[i]),
            .bout (bw2[i+1])
        );
    end

    assign neg = r[RW-1];

    // Upper magnitude bits and the final borrow only feed the sign.
    assign unused_bits = ^{bw2[RW], r[RW-2:WIDTH]};

    always_comb begin
        f_d = r[WIDTH-1:0];
`ifdef RCA_SUB_SAT_EN
        if (neg) begin
            f_d = '0;
        end
`endif
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q      <= '0;
            s1_q      <= '0;
            v1_q      <= 1'b0;
            F         <= '0;
            uf        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1_q      <= in_valid;
            out_valid <= v1_q;
            if (in_valid) begin
                d1_q <= d1_d;
                s1_q <= s1_d;
            end
            // Bubbles leave the last result on F/uf untouched.
            if (v1_q) begin
                F  <= f_d;
                uf <= neg;
            end
        end
    end

endmodule

// File: tb/tb_rca_pipe_sub.sv
// Scoreboard bench for rca_pipe_sub: the stimulus side pushes the expected
// result of every accepted operand set, the monitor pops on each new output.
module tb_rca_pipe_sub;
    import rca_pkg::*;

    localparam int W = RCA_WIDTH_DEF;

    typedef struct packed {
        logic [W-1:0] f;
        logic         uf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         in_valid;
    logic [W-1:0] a, b, c, d;
    logic [W-1:0] f;
    logic         uf;
    logic         out_valid;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    logic last_en = 1'b0;

    always #5 clk = ~clk;

    rca_pipe_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .C         (c),
        .D         (d),
        .F         (f),
        .uf        (uf),
        .out_valid (out_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole expression.
    function automatic exp_t model(input logic [W-1:0] a_, b_, c_, d_);
        int   t;
        exp_t e;
        t    = int'(a_) - int'(b_) - int'(c_) - int'(d_);
        e.uf = (t < 0);
        e.f  = t[W-1:0];
`ifdef RCA_SUB_SAT_EN
        if (t < 0) e.f = '0;
`endif
        return e;
    endfunction

    task automatic step(input logic e_, input logic v_,
                        input logic [W-1:0] a_, b_, c_, d_);
        en       = e_;
        in_valid = v_;
        a = a_; b = b_; c = c_; d = d_;
        if (e_ && v_ && !rst) sbq.push_back(model(a_, b_, c_, d_));
        @(posedge clk);
        #1;
    endtask

    task automatic rstep(input logic e_, input logic v_);
        step(e_, v_, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Outputs only change on an enabled edge, so a result is new exactly when
    // the preceding edge was enabled and out_valid is high.
    always @(posedge clk) last_en <= en && !rst;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && last_en && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got F=%0d uf=%0d expected no result at %0t",
                         f, uf, $time);
            end else begin
                e = sbq.pop_front();
                pops++;
                chk("F", 32'(f), 32'(e.f));
                chk("uf", 32'(uf), 32'(e.uf));
            end
        end
    end

    initial begin
        int p0;
        logic [W-1:0] fb;
        logic         ub;

        rst = 1'b1;
        en = 1'b1; in_valid = 1'b1;
        a = '1; b = '0; c = '0; d = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_F", 32'(f), 0);
        chk("reset_uf", 32'(uf), 0);
        rst = 1'b0;

        // Directed vectors
        step(1, 1, 15, 5, 3, 2);
        step(1, 1, 3, 5, 3, 0);
        step(1, 1, 0, 15, 15, 15);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 15, 0, 0, 0);
        for (int i = 0; i < 3; i++) rstep(1, 0);

        // Back-to-back stream of 8
        p0 = pops;
        for (int i = 0; i < 8; i++) rstep(1, 1);
        for (int i = 0; i < 3; i++) rstep(1, 0);
        chk("stream_count", 32'(pops - p0), 8);

        // Hold with en low: nothing may move
        fb = f;
        ub = uf;
        step(1, 1, 9, 2, 1, 1);
        for (int i = 0; i < 3; i++) begin
            rstep(0, 1);
            chk("hold_out_valid", 32'(out_valid), 0);
            chk("hold_F", 32'(f), 32'(fb));
            chk("hold_uf", 32'(uf), 32'(ub));
        end
        p0 = pops;
        rstep(1, 0);
        @(negedge clk); #1;
        chk("hold_emerge", 32'(pops - p0), 1);
        for (int i = 0; i < 2; i++) rstep(1, 0);

        // Random traffic with random enable and bubbles
        for (int i = 0; i < 300; i++) begin
            rstep(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) rstep(1, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) rstep(1, 1);
        chk("pre_reset_out_valid", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_F", 32'(f), 0);
        chk("async_uf", 32'(uf), 0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rstep(1, 1);
        for (int i = 0; i < 3; i++) rstep(1, 0);

        chk("drain_empty", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
